// File: rtl/clock_pkg.sv
// Shared definitions for the timekeeping datapath.
//   SEC_MAX / MIN_MAX : BCD wrap points for seconds and minutes
//   CNT_SEC/MIN/HOUR  : bit positions inside i_Counters_Enable_Count
//   bin_to_bcd        : converts a binary 0..99 constant to packed BCD
package clock_pkg;

  localparam logic [7:0] SEC_MAX = 8'h59;
  localparam logic [7:0] MIN_MAX = 8'h59;

  localparam int CNT_SEC  = 0;
  localparam int CNT_MIN  = 1;
  localparam int CNT_HOUR = 2;

  // Elaboration-time helper; HOUR_MAX is given in binary.
  function automatic logic [7:0] bin_to_bcd(input int v);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'(v / 10);
    ones = 4'(v % 10);
    return {tens, ones};
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit packed-BCD counter that wraps from MAX_BCD to 00.
//   i_Clock  : clock
//   i_Reset  : synchronous active-high clear
//   i_Clear  : synchronous clear (lower priority than i_Reset)
//   i_Step   : advance by one
//   o_Value  : registered BCD value
//   o_At_Max : value currently equals MAX_BCD (used to form carries)
module bcd_mod_counter #(
  parameter logic [7:0] MAX_BCD = 8'h59
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Clear,
  input  logic       i_Step,
  output logic [7:0] o_Value,
  output logic       o_At_Max
);

  logic [7:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (i_Clear) begin
      value_d = 8'h00;
    end else if (i_Step) begin
      // Wrap is checked on the full BCD value before the digit roll.
      if (value_q == MAX_BCD)
        value_d = 8'h00;
      else if (value_q[3:0] == 4'd9)
        value_d = {value_q[7:4] + 4'd1, 4'd0};
      else
        value_d = {value_q[7:4], value_q[3:0] + 4'd1};
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) value_q <= 8'h00;
    else         value_q <= value_d;
  end

  assign o_Value  = value_q;
  assign o_At_Max = (value_q == MAX_BCD);

endmodule

// File: rtl/time_counters.sv
// Hours/minutes/seconds timekeeping in packed BCD.
// Run mode counts i_Tick_1Hz with carries; set mode steps enabled fields
// independently on i_Increment.
//   i_Clock, i_Reset              : clock, synchronous active-high reset
//   i_Tick_1Hz, i_Increment       : one-cycle strobes
//   i_Counters_Reset              : clears seconds only
//   i_Counters_Enable_Increment   : 1 = set mode, 0 = run mode
//   i_Counters_Enable_Count[2:0]  : per-field enables {hour, min, sec}
//   o_Seconds/o_Minutes/o_Hours   : registered BCD fields
//   o_Day_Wrap                    : one-cycle pulse on rollover to 00:00:00
module time_counters
  import clock_pkg::*;
#(
  parameter int HOUR_MAX = 23
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Tick_1Hz,
  input  logic       i_Increment,
  input  logic       i_Counters_Reset,
  input  logic       i_Counters_Enable_Increment,
  input  logic [2:0] i_Counters_Enable_Count,
  output logic [7:0] o_Seconds,
  output logic [7:0] o_Minutes,
  output logic [7:0] o_Hours,
  output logic       o_Day_Wrap
);

  localparam logic [7:0] HOUR_MAX_BCD = bin_to_bcd(HOUR_MAX);

  logic set_mode, hold;
  logic sec_step, min_step, hour_step;
  logic sec_carry, min_carry;
  logic sec_at_max, min_at_max, hour_at_max;
  logic day_wrap_q, day_wrap_d;

  assign set_mode = i_Counters_Enable_Increment;
  // Counters_Reset suppresses every step, so no carry can leak out of
  // the seconds clear.
  assign hold     = i_Counters_Reset;

  always_comb begin
    sec_step   = 1'b0;
    min_step   = 1'b0;
    hour_step  = 1'b0;
    sec_carry  = 1'b0;
    min_carry  = 1'b0;
    day_wrap_d = 1'b0;
    if (!hold) begin
      if (set_mode) begin
        sec_step  = i_Increment & i_Counters_Enable_Count[CNT_SEC];
        min_step  = i_Increment & i_Counters_Enable_Count[CNT_MIN];
        hour_step = i_Increment & i_Counters_Enable_Count[CNT_HOUR];
      end else begin
        // A disabled field never steps, which also kills every carry above it.
        sec_step   = i_Tick_1Hz & i_Counters_Enable_Count[CNT_SEC];
        sec_carry  = sec_step & sec_at_max;
        min_step   = sec_carry & i_Counters_Enable_Count[CNT_MIN];
        min_carry  = min_step & min_at_max;
        hour_step  = min_carry & i_Counters_Enable_Count[CNT_HOUR];
        day_wrap_d = hour_step & hour_at_max;
      end
    end
  end

  bcd_mod_counter #(.MAX_BCD(SEC_MAX)) u_sec (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .i_Clear (i_Counters_Reset),
    .i_Step  (sec_step),
    .o_Value (o_Seconds),
    .o_At_Max(sec_at_max)
  );

  bcd_mod_counter #(.MAX_BCD(MIN_MAX)) u_min (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .i_Clear (1'b0),
    .i_Step  (min_step),
    .o_Value (o_Minutes),
    .o_At_Max(min_at_max)
  );

  bcd_mod_counter #(.MAX_BCD(HOUR_MAX_BCD)) u_hour (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .i_Clear (1'b0),
    .i_Step  (hour_step),
    .o_Value (o_Hours),
    .o_At_Max(hour_at_max)
  );

  always_ff @(posedge i_Clock) begin
    if (i_Reset) day_wrap_q <= 1'b0;
    else         day_wrap_q <= day_wrap_d;
  end

  assign o_Day_Wrap = day_wrap_q;

endmodule

// File: tb/tb_time_counters.sv
module tb_time_counters;

  logic       clk = 1'b0;
  logic       rst, tick, inc, cr, ei;
  logic [2:0] ec;
  logic [7:0] sec, min, hr;
  logic       wrap;
  logic [7:0] sec11, min11, hr11;
  logic       wrap11;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  time_counters #(.HOUR_MAX(23)) dut (
    .i_Clock(clk), .i_Reset(rst), .i_Tick_1Hz(tick), .i_Increment(inc),
    .i_Counters_Reset(cr), .i_Counters_Enable_Increment(ei),
    .i_Counters_Enable_Count(ec),
    .o_Seconds(sec), .o_Minutes(min), .o_Hours(hr), .o_Day_Wrap(wrap)
  );

  time_counters #(.HOUR_MAX(11)) dut11 (
    .i_Clock(clk), .i_Reset(rst), .i_Tick_1Hz(tick), .i_Increment(inc),
    .i_Counters_Reset(cr), .i_Counters_Enable_Increment(ei),
    .i_Counters_Enable_Count(ec),
    .o_Seconds(sec11), .o_Minutes(min11), .o_Hours(hr11), .o_Day_Wrap(wrap11)
  );

  // Apply one cycle of inputs, sample #1 after the edge, then idle strobes.
  task automatic cyc(input logic r, input logic t, input logic i,
                     input logic c, input logic e, input logic [2:0] en);
    rst = r; tick = t; inc = i; cr = c; ei = e; ec = en;
    @(posedge clk);
    #1;
    rst = 0; tick = 0; inc = 0; cr = 0;
  endtask

  // Reset, then load h:m:s (decimal) field by field in set mode.
  task automatic preload(input int h, input int m, input int s);
    cyc(1, 0, 0, 0, 0, 3'b000);
    for (int k = 0; k < s; k++) cyc(0, 0, 1, 0, 1, 3'b001);
    for (int k = 0; k < m; k++) cyc(0, 0, 1, 0, 1, 3'b010);
    for (int k = 0; k < h; k++) cyc(0, 0, 1, 0, 1, 3'b100);
  endtask

  task automatic test_reset;
    for (int k = 0; k < 5; k++) cyc(0, 1, 0, 0, 0, 3'b111);
    cyc(1, 1, 1, 0, 0, 3'b111);
    vectors++;
    if ({hr, min, sec} !== 24'h000000) begin
      miscompares++;
      $display("FAIL reset_time got %h:%h:%h want 00:00:00", hr, min, sec);
    end
    vectors++;
    if (wrap !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_wrap got %b want 0", wrap);
    end
    for (int k = 0; k < 3; k++) cyc(0, 1, 0, 0, 0, 3'b111);
    vectors++;
    if ({hr, min, sec} !== 24'h000003) begin
      miscompares++;
      $display("FAIL reset_then_3_ticks got %h:%h:%h want 00:00:03", hr, min, sec);
    end
    // reset wins over a coincident set-mode increment
    cyc(1, 0, 1, 0, 1, 3'b111);
    vectors++;
    if ({hr, min, sec} !== 24'h000000) begin
      miscompares++;
      $display("FAIL reset_mid_set got %h:%h:%h want 00:00:00", hr, min, sec);
    end
  endtask

  task automatic test_day_wrap;
    preload(23, 59, 58);
    vectors++;
    if ({hr, min, sec} !== 24'h235958) begin
      miscompares++;
      $display("FAIL preload got %h:%h:%h want 23:59:58", hr, min, sec);
    end
    cyc(0, 1, 0, 0, 0, 3'b111);
    vectors++;
    if ({hr, min, sec, wrap} !== {24'h235959, 1'b0}) begin
      miscompares++;
      $display("FAIL wrap_tick1 got %h:%h:%h w%b want 23:59:59 w0", hr, min, sec, wrap);
    end
    cyc(0, 1, 0, 0, 0, 3'b111);
    vectors++;
    if ({hr, min, sec, wrap} !== {24'h000000, 1'b1}) begin
      miscompares++;
      $display("FAIL wrap_tick2 got %h:%h:%h w%b want 00:00:00 w1", hr, min, sec, wrap);
    end
    cyc(0, 0, 0, 0, 0, 3'b111);
    vectors++;
    if ({hr, min, sec, wrap} !== {24'h000000, 1'b0}) begin
      miscompares++;
      $display("FAIL wrap_pulse_end got %h:%h:%h w%b want 00:00:00 w0", hr, min, sec, wrap);
    end
  endtask

  task automatic test_set_minutes;
    preload(5, 59, 0);
    cyc(0, 0, 1, 0, 1, 3'b010);
    vectors++;
    if ({hr, min, sec, wrap} !== {24'h050000, 1'b0}) begin
      miscompares++;
      $display("FAIL set_min_wrap got %h:%h:%h w%b want 05:00:00 w0", hr, min, sec, wrap);
    end
    for (int k = 0; k < 5; k++) cyc(0, 1, 0, 0, 1, 3'b111);
    vectors++;
    if ({hr, min, sec} !== 24'h050000) begin
      miscompares++;
      $display("FAIL set_ignores_tick got %h:%h:%h want 05:00:00", hr, min, sec);
    end
    // all fields step independently, no carry from 59 seconds
    preload(4, 59, 59);
    cyc(0, 0, 1, 0, 1, 3'b111);
    vectors++;
    if ({hr, min, sec, wrap} !== {24'h050000, 1'b0}) begin
      miscompares++;
      $display("FAIL set_multi got %h:%h:%h w%b want 05:00:00 w0", hr, min, sec, wrap);
    end
    // run mode ignores increment
    cyc(0, 0, 1, 0, 0, 3'b111);
    vectors++;
    if ({hr, min, sec} !== 24'h050000) begin
      miscompares++;
      $display("FAIL run_ignores_inc got %h:%h:%h want 05:00:00", hr, min, sec);
    end
  endtask

  task automatic test_hour_wrap;
    preload(23, 0, 0);
    cyc(0, 0, 1, 0, 1, 3'b100);
    vectors++;
    if ({hr, wrap} !== {8'h00, 1'b0}) begin
      miscompares++;
      $display("FAIL hour23_wrap got %h w%b want 00 w0", hr, wrap);
    end
    cyc(1, 0, 0, 0, 0, 3'b000);
    for (int k = 0; k < 11; k++) cyc(0, 0, 1, 0, 1, 3'b100);
    vectors++;
    if (hr11 !== 8'h11) begin
      miscompares++;
      $display("FAIL hour11_load got %h want 11", hr11);
    end
    cyc(0, 0, 1, 0, 1, 3'b100);
    vectors++;
    if ({hr11, wrap11} !== {8'h00, 1'b0}) begin
      miscompares++;
      $display("FAIL hour11_wrap got %h w%b want 00 w0", hr11, wrap11);
    end
  endtask

  task automatic test_counters_reset;
    preload(4, 12, 37);
    cyc(0, 1, 0, 1, 0, 3'b000);
    vectors++;
    if ({hr, min, sec} !== 24'h041200) begin
      miscompares++;
      $display("FAIL cnt_reset got %h:%h:%h want 04:12:00", hr, min, sec);
    end
    cyc(0, 1, 0, 0, 0, 3'b111);
    vectors++;
    if ({hr, min, sec} !== 24'h041201) begin
      miscompares++;
      $display("FAIL cnt_reset_then_tick got %h:%h:%h want 04:12:01", hr, min, sec);
    end
    // clear at 59 with a tick: no carry into minutes
    preload(23, 59, 59);
    cyc(0, 1, 0, 1, 0, 3'b111);
    vectors++;
    if ({hr, min, sec, wrap} !== {24'h235900, 1'b0}) begin
      miscompares++;
      $display("FAIL cnt_reset_no_carry got %h:%h:%h w%b want 23:59:00 w0", hr, min, sec, wrap);
    end
    // enables 000 in run mode freeze everything
    for (int k = 0; k < 3; k++) cyc(0, 1, 0, 0, 0, 3'b000);
    vectors++;
    if ({hr, min, sec} !== 24'h235900) begin
      miscompares++;
      $display("FAIL freeze_000 got %h:%h:%h want 23:59:00", hr, min, sec);
    end
  endtask

  task automatic test_carry_block;
    preload(3, 7, 59);
    cyc(0, 1, 0, 0, 0, 3'b001);
    vectors++;
    if ({hr, min, sec} !== 24'h030700) begin
      miscompares++;
      $display("FAIL carry_dropped got %h:%h:%h want 03:07:00", hr, min, sec);
    end
    preload(0, 0, 9);
    cyc(0, 1, 0, 0, 0, 3'b001);
    vectors++;
    if (sec !== 8'h10) begin
      miscompares++;
      $display("FAIL bcd_09_to_10 got %h want 10", sec);
    end
    // hours disabled: minute carry discarded, no day wrap
    preload(23, 59, 59);
    cyc(0, 1, 0, 0, 0, 3'b011);
    vectors++;
    if ({hr, min, sec, wrap} !== {24'h230000, 1'b0}) begin
      miscompares++;
      $display("FAIL hour_blocked got %h:%h:%h w%b want 23:00:00 w0", hr, min, sec, wrap);
    end
  endtask

  task automatic test_back_to_back;
    preload(0, 0, 0);
    for (int k = 0; k < 61; k++) cyc(0, 1, 0, 0, 0, 3'b111);
    vectors++;
    if ({hr, min, sec} !== 24'h000101) begin
      miscompares++;
      $display("FAIL b2b_61_ticks got %h:%h:%h want 00:01:01", hr, min, sec);
    end
    preload(9, 59, 59);
    cyc(0, 1, 0, 0, 0, 3'b111);
    vectors++;
    if ({hr, min, sec, wrap} !== {24'h100000, 1'b0}) begin
      miscompares++;
      $display("FAIL hour_bcd_roll got %h:%h:%h w%b want 10:00:00 w0", hr, min, sec, wrap);
    end
  endtask

  initial begin
    rst = 1; tick = 0; inc = 0; cr = 0; ei = 0; ec = 3'b000;
    @(posedge clk); #1;
    test_reset();
    test_day_wrap();
    test_set_minutes();
    test_hour_wrap();
    test_counters_reset();
    test_carry_block();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/time_counters.md
Name: time_counters

Overview:
- Timekeeping datapath directly downstream of control_unit.
- Holds hours, minutes and seconds as packed BCD.
- Counts a 1 Hz tick in run mode, or single-step pulses in set mode.
- Reset and enable strobes come straight from control_unit outputs; the BCD outputs feed the display driver.

Parameters:
- HOUR_MAX, 23, last valid hour value (binary 0..99, e.g. 23 or 11); hours wrap from HOUR_MAX to 00.

Ports:
- i_Clock  in  1  system clock
- i_Reset  in  1  synchronous, active-high; clears all fields
- i_Tick_1Hz  in  1  one-cycle strobe from prescaler, once per second
- i_Increment  in  1  one-cycle strobe from debounced increment button
- i_Counters_Reset  in  1  from control_unit; clears seconds
- i_Counters_Enable_Increment  in  1  from control_unit; 1 = set mode, 0 = run mode
- i_Counters_Enable_Count  in  3  from control_unit; bit0 = seconds, bit1 = minutes, bit2 = hours
- o_Seconds  out  8  BCD seconds, 00..59
- o_Minutes  out  8  BCD minutes, 00..59
- o_Hours  out  8  BCD hours, 00..HOUR_MAX
- o_Day_Wrap  out  1  one-cycle pulse when the clock rolls from HOUR_MAX:59:59 to 00:00:00

Behaviour:
- Interface: one clock, i_Clock. Reset is synchronous and active-high, i_Reset.
- Reset: on a rising edge with i_Reset=1, o_Seconds, o_Minutes and o_Hours all go to 8'h00, and o_Day_Wrap goes to 0.
- Registered outputs: every input is sampled at rising edge N; its effect is visible after edge N, i.e. one cycle of latency. There are no combinational paths from input to output.
- Priority per cycle, highest first: i_Reset > i_Counters_Reset > set mode > run mode.
- i_Counters_Reset=1:
  - seconds are forced to 00; minutes and hours hold;
  - a coincident tick or increment is ignored, with no carry;
  - o_Day_Wrap is 0.
- Set mode (Enable_Increment=1):
  - i_Tick_1Hz is ignored.
  - On i_Increment=1, each field whose enable bit is set increments by 1.
  - Wrap points: seconds and minutes 59->00, hours HOUR_MAX->00.
  - No carry propagates between fields; o_Day_Wrap stays 0.
  - Several enable bits set at once: each enabled field steps independently.
- Run mode (Enable_Increment=0):
  - i_Increment is ignored.
  - On a tick with Enable_Count[0]=1, seconds increment.
  - sec_carry = seconds==59 and the seconds step occurs. Minutes increment on sec_carry if Enable_Count[1]=1.
  - min_carry = minutes==59 and the minutes step occurs. Hours increment on min_carry if Enable_Count[2]=1.
  - A disabled field holds its value and blocks all carries above it. A carry into a disabled field is discarded, not queued.
- o_Day_Wrap: high for exactly the one cycle after the edge at which the hours field wraps through a carry (run mode only).
- BCD arithmetic:
  - ones digit 9 -> 0 with a tens increment;
  - wrap is detected on the full BCD value, e.g. 8'h59 or the BCD encoding of HOUR_MAX;
  - nibbles never hold A..F.
- Illegal held values cannot arise: the only load is clear.
- Enable_Count=000 with Enable_Increment=0 (control_unit RESET_SEC state): all fields freeze; the seconds clear is governed by i_Counters_Reset alone.
- Reset mid-set or mid-carry: i_Reset wins that cycle. Nothing pending survives, since no state exists besides the three fields and o_Day_Wrap.

Decomposition:
- Shared package clock_pkg holds:
  - localparams SEC_MAX=8'h59 and MIN_MAX=8'h59;
  - enable bit indices CNT_SEC=0, CNT_MIN=1, CNT_HOUR=2.
- One natural sub-module, bcd_mod_counter:
  - parameter MAX_BCD;
  - inputs i_Clock, i_Reset, i_Clear, i_Step;
  - outputs o_Value[7:0] and o_At_Max;
  - instantiated three times.
- The top level computes i_Step per field from mode, tick, increment, enables and carries.
- o_At_Max of the lower field, gated by its step, forms the carry.

Test Plan:
- i_Reset for 1 cycle with ticks present -> all fields 00, o_Day_Wrap 0; then 3 ticks with enables 111 -> o_Seconds=8'h03.
- Preload 23:59:58 via set mode, enables 111, run mode, 2 ticks -> after the first tick 23:59:59; after the second 00:00:00 with o_Day_Wrap=1 for exactly one cycle.
- Set mode, enables 010, minutes 8'h59, i_Increment once -> minutes 00, hours unchanged, o_Day_Wrap 0; 5 ticks during set mode -> no change.
- Set mode, enables 100, HOUR_MAX=23, hours 8'h23, i_Increment -> hours 8'h00; repeat with HOUR_MAX=11 from 8'h11 -> 8'h00.
- Seconds 8'h37, i_Counters_Reset=1 coincident with a tick and enables 000 -> seconds 00, minutes and hours hold; then enables 111 and a tick -> 8'h01.
- Run mode, enables 001, seconds 8'h59, tick -> seconds 00, minutes unchanged (carry dropped); BCD check that 8'h09 + tick = 8'h10, never 8'h0A.
